// File: rtl/musa_pkg.sv
// Shared defaults and types for the register bank and the execute stage.
package musa_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  typedef logic signed [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0]        reg_addr_t;

endpackage

// File: rtl/register_bank_if.sv
// Read/write/debug bus of the register bank.
// The master side drives requests and write-back; the slave side is the bank.
interface register_bank_if #(
  parameter int DATA_WIDTH = musa_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = musa_pkg::ADDR_WIDTH
);

  logic                  rd_en;
  logic                  hold;
  logic [ADDR_WIDTH-1:0] rs_addr;
  logic [ADDR_WIDTH-1:0] rt_addr;
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;
  logic                  op_valid;
  logic                  we;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] dbg_addr;
  logic [DATA_WIDTH-1:0] dbg_data;

  modport master (
    output rd_en, hold, rs_addr, rt_addr, we, wr_addr, wr_data, dbg_addr,
    input  op1, op2, op_valid, dbg_data
  );

  modport slave (
    input  rd_en, hold, rs_addr, rt_addr, we, wr_addr, wr_data, dbg_addr,
    output op1, op2, op_valid, dbg_data
  );

endinterface

// File: rtl/regbank_read_port.sv
// One operand source selector: zero-register masking plus optional
// same-edge write forwarding.
// Optional feature macro: REGBANK_BYPASS_EN (forward wr_data on address match).
module regbank_read_port #(
  parameter int DATA_WIDTH = musa_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = musa_pkg::ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_stored,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] src
);

`ifndef REGBANK_BYPASS_EN
  // Write-side inputs only matter when forwarding is built in.
  logic unused_wr;
  assign unused_wr = ^{we, wr_addr, wr_data};
`endif

  // Pick stored contents, forwarded write data, or a hard zero for r0.
  always_comb begin
    src = rd_stored;
`ifdef REGBANK_BYPASS_EN
    if (we && (wr_addr == rd_addr)) begin
      src = wr_data;
    end
`endif
    // Masking last so r0 is never forwarded when it is hard-wired.
    if ((ZERO_REG != 0) && (rd_addr == '0)) begin
      src = '0;
    end
  end

endmodule

// File: rtl/register_bank.sv
// Two-read/one-write register bank with registered operand outputs.
// Optional feature macro: REGBANK_BYPASS_EN (same-edge write-to-read forwarding,
// implemented inside regbank_read_port).
module register_bank #(
  parameter int DATA_WIDTH = musa_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = musa_pkg::ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic            clk,
  input  logic            reset,
  register_bank_if.slave  bus
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] op1_q, op1_d;
  logic [DATA_WIDTH-1:0] op2_q, op2_d;
  logic                  op_valid_q, op_valid_d;
  logic [DATA_WIDTH-1:0] src_rs, src_rt;
  logic                  wr_ok;

  regbank_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_rs (
    .rd_addr   (bus.rs_addr),
    .rd_stored (regs_q[bus.rs_addr]),
    .we        (bus.we),
    .wr_addr   (bus.wr_addr),
    .wr_data   (bus.wr_data),
    .src       (src_rs)
  );

  regbank_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_rt (
    .rd_addr   (bus.rt_addr),
    .rd_stored (regs_q[bus.rt_addr]),
    .we        (bus.we),
    .wr_addr   (bus.wr_addr),
    .wr_data   (bus.wr_data),
    .src       (src_rt)
  );

  // A write lands unless it targets the hard-wired zero register.
  assign wr_ok = bus.we && !((ZERO_REG != 0) && (bus.wr_addr == '0));

  // Next register contents: single write port, independent of hold/rd_en.
  always_comb begin
    regs_d = regs_q;
    if (wr_ok) begin
      regs_d[bus.wr_addr] = bus.wr_data;
    end
  end

  // Next operand outputs: hold freezes everything, otherwise rd_en loads.
  always_comb begin
    op1_d      = op1_q;
    op2_d      = op2_q;
    op_valid_d = op_valid_q;
    if (!bus.hold) begin
      op_valid_d = bus.rd_en;
      if (bus.rd_en) begin
        op1_d = src_rs;
        op2_d = src_rt;
      end
    end
  end

  // Storage array with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Operand output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op1_q      <= '0;
      op2_q      <= '0;
      op_valid_q <= 1'b0;
    end else begin
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      op_valid_q <= op_valid_d;
    end
  end

  assign bus.op1      = op1_q;
  assign bus.op2      = op2_q;
  assign bus.op_valid = op_valid_q;
  assign bus.dbg_data = regs_q[bus.dbg_addr];

endmodule

// File: doc/register_bank.md
# register_bank

Two-read/one-write general-purpose register bank feeding the execute-stage ALU. It holds the architectural registers and delivers the two operands selected by the decoded instruction as registered `op1`/`op2`, one cycle after the read request. These drive the ALU `op1`/`op2` inputs directly. The ALU result is written back through a single write port, which includes an optional same-cycle write-to-read bypass.

## Interface
- `DATA_WIDTH`, 32: register and operand width; matches ALU operand width.
- `ADDR_WIDTH`, 5: register address width; the bank holds 2^ADDR_WIDTH registers.
- `ZERO_REG`, 1: when 1, register 0 reads as 0 and ignores writes. When 0, register 0 is ordinary.
- `clk` in 1: the only clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all registers and outputs immediately.
- `rd_en` in 1: read request for this cycle.
- `hold` in 1: stall from downstream; freezes the operand outputs.
- `rs_addr` in ADDR_WIDTH: source register for `op1`.
- `rt_addr` in ADDR_WIDTH: source register for `op2`.
- `op1` out DATA_WIDTH: registered first operand, to ALU `op1`.
- `op2` out DATA_WIDTH: registered second operand, to ALU `op2`.
- `op_valid` out 1: `op1`/`op2` hold a fresh read.
- `we` in 1: write enable.
- `wr_addr` in ADDR_WIDTH: write register.
- `wr_data` in DATA_WIDTH: write data (ALU result).
- `dbg_addr` in ADDR_WIDTH: bench-only inspection address.
- `dbg_data` out DATA_WIDTH: combinational `regs[dbg_addr]`, no bypass.

## Operation
- **Reset.** While `reset`=1:
  - all registers are 0;
  - `op1`=0, `op2`=0, `op_valid`=0;
  - `dbg_data` follows the cleared contents.
- **Reset mid-operation.** Any in-flight read or write is discarded. The first edge after deassertion behaves as a normal cycle.
- **Write.** At an edge with `we`=1, `regs[wr_addr]` <= `wr_data`.
  - With `ZERO_REG`=1 and `wr_addr`=0, the write is dropped.
  - Writes are never blocked by `hold` or `rd_en`.
- **Read and hold.** The edge updates the operand outputs according to `hold` and `rd_en`:
  - `hold`=1: `op1`, `op2` and `op_valid` all keep their values. `rs_addr`/`rt_addr` are ignored and the request is not queued.
  - `hold`=0, `rd_en`=1: `op1` <= src(`rs_addr`), `op2` <= src(`rt_addr`), `op_valid` <= 1.
  - `hold`=0, `rd_en`=0: `op_valid` <= 0; `op1`/`op2` keep their values.
- **Source value src(a):**
  - 0 when `ZERO_REG`=1 and a=0;
  - otherwise the bypassed value if a bypass applies (see Configuration);
  - otherwise `regs[a]` before the edge.
- `rs_addr`=`rt_addr` is legal; both operands receive the same value.
- **No arithmetic.** Values are stored and returned bit-exact, with no sign handling. The signed interpretation belongs to the ALU.

## Timing
- Read latency is 1 cycle: the address is presented in cycle N, and operands and `op_valid` are visible after edge N.
- Write latency is 1 cycle, whether observed through `dbg_data` or through a subsequent read.
- Read-after-write in the same edge (`we`=1, `wr_addr`=`rs_addr`/`rt_addr`≠0 or `ZERO_REG`=0) is governed by `REGBANK_BYPASS_EN`.
- Back-to-back reads sustain one operand pair per cycle while `hold`=0.
- `hold` is sampled at the edge only; there is no combinational path from `hold` to the outputs.

## Configuration
- The macro is `REGBANK_BYPASS_EN`.
- **Defined:** a same-edge write to a register being read forwards `wr_data` into `op1`/`op2`. The operand therefore equals the value written at that edge.
- **Undefined:** no forwarding. The operand receives the pre-write contents, and the new value is seen by the next read.
- Register 0 is never forwarded when `ZERO_REG`=1.

## Structure
- Shared package `musa_pkg`:
  - `DATA_WIDTH` and `ADDR_WIDTH` defaults;
  - the `word_t` typedef (logic signed [31:0]);
  - the `reg_addr_t` typedef (logic [4:0]).
- One sub-module, `regbank_read_port`. It implements src(a), i.e. zero-register masking plus bypass mux, and is instantiated twice (`rs`, `rt`).
- The storage array and write logic live in `register_bank`.

## Test plan
- **Reset state:** assert `reset` mid-stream after writing `regs[3]`=32'h1234 -> `op1`=`op2`=0 and `op_valid`=0 immediately; `dbg_addr`=3 gives 0.
- **Write then read:** write `regs[5]`=-7 and `regs[6]`=2147483647; next cycle read rs=5, rt=6 -> one edge later `op1`=-7, `op2`=2147483647, `op_valid`=1.
- **Zero register:** write `regs[0]`=32'hDEADBEEF, read rs=0 -> `op1`=0 (`ZERO_REG`=1). With `ZERO_REG`=0 -> `op1`=32'hDEADBEEF.
- **Same-edge bypass:** `regs[7]`=10; at one edge write `regs[7]`=99 while reading rs=7, rt=7 -> `op1`=`op2`=99 with `REGBANK_BYPASS_EN`, =10 without. The following read gives 99 in both builds.
- **Hold:** read rs=5 (`op1`=-7), then `hold`=1 for 3 cycles while rs changes to 6 and `we` writes `regs[5]`=1 -> `op1` stays -7 and `op_valid` stays 1. After release with `rd_en`=1 and rs=5 -> `op1`=1.
- **Random sweep:** 200 random `we`/`wr_addr`/`wr_data`/`rd_en`/`hold`/addresses compared against a reference model of registers plus output registers; zero mismatches.
